// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with synchronizer, debounce and key decode.
// Optional release debounce: define KEYPAD_RELEASE_DEBOUNCE_EN.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] num,
    output logic [3:0] symbol,
    output logic       key
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] LAST_DEB = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       cols_s;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       num_q, num_d;
    logic [3:0]       sym_q, sym_d;
    logic             key_q, key_d;

    logic       one_low;
    logic [1:0] col_idx;
    logic [3:0] code;
    logic [3:0] dec_num;
    logic [3:0] dec_sym;

    // NOTE: col is asynchronous; only the second flop's output may feed logic.
    assign cols_s = sync2_q;

    // Decode the latched pattern; valid only when exactly one column is low.
    always_comb begin
        one_low = 1'b1;
        col_idx = 2'd0;
        case (pat_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
        code = {row_idx_q, col_idx};
        if (code < 4'd10) begin
            dec_num = code;
            dec_sym = 4'b1111;
        end else begin
            dec_num = 4'b0000;
            dec_sym = code - 4'd9;
        end
    end

    // NOTE: every _d gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        div_cnt_d = div_cnt_q;
        deb_cnt_d = deb_cnt_q;
        pat_d     = pat_q;
        num_d     = num_q;
        sym_d     = sym_q;
        key_d     = key_q;

        case (state_q)
            SCAN: begin
                if (div_cnt_q == LAST_DIV) begin
                    div_cnt_d = '0;
                    if (cols_s != 4'b1111) begin
                        pat_d     = cols_s;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (cols_s != pat_q) begin
                    state_d   = SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    div_cnt_d = '0;
                end else if (deb_cnt_q == LAST_DEB) begin
                    if (one_low) begin
                        key_d   = 1'b1;
                        num_d   = dec_num;
                        sym_d   = dec_sym;
                        state_d = PRESSED;
                    end else begin
                        // Multi-key chord: wait out the interval, then move on.
                        state_d   = SCAN;
                        row_idx_d = row_idx_q + 2'd1;
                        div_cnt_d = '0;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            PRESSED: begin
                if (cols_s == 4'b1111) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASE;
                end
            end

            RELEASE: begin
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
                if (cols_s != 4'b1111) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == LAST_DEB) begin
                    key_d     = 1'b0;
                    state_d   = SCAN;
                    row_idx_d = 2'd0;
                    div_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
`else
                key_d     = 1'b0;
                state_d   = SCAN;
                row_idx_d = 2'd0;
                div_cnt_d = '0;
`endif
            end

            default: state_d = SCAN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SCAN;
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            row_idx_q <= 2'd0;
            div_cnt_q <= '0;
            deb_cnt_q <= '0;
            pat_q     <= 4'b1111;
            num_q     <= 4'b0000;
            sym_q     <= 4'b0000;
            key_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= col;
            sync2_q   <= sync1_q;
            row_idx_q <= row_idx_d;
            div_cnt_q <= div_cnt_d;
            deb_cnt_q <= deb_cnt_d;
            pat_q     <= pat_d;
            num_q     <= num_d;
            sym_q     <= sym_d;
            key_q     <= key_d;
        end
    end

    assign row    = ~(4'b0001 << row_idx_q);
    assign num    = num_q;
    assign symbol = sym_q;
    assign key    = key_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad model driven from row, with a
// scoreboard of expected {num, symbol} popped on each rising edge of key.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 8;
    localparam int DEBOUNCE_CYC = 16;
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
    // 2 sync cycles, 1 to leave PRESSED, then DEBOUNCE_CYC clean cycles
    localparam int DROP_CLEAN  = 3 + DEBOUNCE_CYC;
    // last bounce ends at cycle 6; 2 sync cycles then DEBOUNCE_CYC clean cycles
    localparam int DROP_BOUNCE = 6 + 2 + DEBOUNCE_CYC;
`else
    localparam int DROP_CLEAN  = 4;
    localparam int DROP_BOUNCE = 4;
`endif

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] sym;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] num;
    logic [3:0] symbol;
    logic       key;

    logic       pressed;
    logic [1:0] press_row;
    logic [3:0] press_mask;
    logic       key_prev;
    exp_t       exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Keypad: the held key pulls its columns low only while its row is driven.
    assign col = (pressed && row[press_row] == 1'b0) ? press_mask : 4'b1111;

    keypad_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .col   (col),
        .row   (row),
        .num   (num),
        .symbol(symbol),
        .key   (key)
    );

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (!(row inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
                errors++;
                $display("FAIL row_one_low: row=%b required exactly one low bit", row);
            end
        end
        if (key === 1'b1 && key_prev !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_key: num=%0d symbol=%b with no accept expected", num, symbol);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (num !== e.num || symbol !== e.sym) begin
                    errors++;
                    $display("FAIL key_decode: num=%0d symbol=%b required num=%0d symbol=%b",
                             num, symbol, e.num, e.sym);
                end
            end
        end
        key_prev <= key;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press(input logic [1:0] r, input logic [3:0] mask);
        press_row  = r;
        press_mask = mask;
        pressed    = 1'b1;
    endtask

    task automatic wait_row(input logic [3:0] pat, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (row === pat) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_key(input logic val, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b1;
        while (key !== val) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ok(input bit ok, input string what);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timed out, required event never seen", what);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        pressed = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: row=%b required 1110", row); end
        if (num !== 4'b0000) begin errors++; $display("FAIL reset_num: num=%b required 0000", num); end
        if (symbol !== 4'b0000) begin errors++; $display("FAIL reset_symbol: symbol=%b required 0000", symbol); end
        if (key !== 1'b0) begin errors++; $display("FAIL reset_key: key=%b required 0", key); end
        reset = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_row;
        for (int k = 1; k <= 4 * SCAN_DIV; k++) begin
            @(negedge clk);
            if (k == SCAN_DIV - 1 || k % SCAN_DIV == 0) begin
                exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
                checks++;
                if (row !== exp_row) begin
                    errors++;
                    $display("FAIL rotation_k%0d: row=%b required %b", k, row, exp_row);
                end
            end
        end
    endtask

    task automatic test_digit();
        bit ok;
        int n;
        int bad;
        wait_row(4'b1011, 64, ok);
        wait_ok(ok, "digit_wait_row2");
        exp_q.push_back('{num: 4'd2, sym: 4'b1111});
        press(2'd0, 4'b1011);
        wait_row(4'b1110, 64, ok);
        wait_ok(ok, "digit_wait_row0");
        wait_key(1'b1, 200, n, ok);
        wait_ok(ok, "digit_key_rise");
        checks++;
        if (n != SCAN_DIV + DEBOUNCE_CYC) begin
            errors++;
            $display("FAIL digit_latency: %0d cycles required %0d", n, SCAN_DIV + DEBOUNCE_CYC);
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (key !== 1'b1 || num !== 4'd2 || symbol !== 4'b1111) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL digit_hold: %0d bad cycles required 0", bad); end
        pressed = 1'b0;
        wait_key(1'b0, 100, n, ok);
        wait_ok(ok, "digit_key_fall");
        checks += 2;
        if (n != DROP_CLEAN) begin
            errors++;
            $display("FAIL digit_release_time: %0d cycles required %0d", n, DROP_CLEAN);
        end
        if (num !== 4'd2 || symbol !== 4'b1111) begin
            errors++;
            $display("FAIL digit_after_release: num=%0d symbol=%b required 2 1111", num, symbol);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_operator();
        bit ok;
        int n;
        exp_q.push_back('{num: 4'd0, sym: 4'b0100});
        press(2'd3, 4'b1101);
        wait_key(1'b1, 300, n, ok);
        wait_ok(ok, "op_key_rise");
        repeat (5) @(negedge clk);
        checks++;
        if (symbol !== 4'b0100 || num !== 4'd0) begin
            errors++;
            $display("FAIL op_held: num=%0d symbol=%b required 0 0100", num, symbol);
        end
        pressed = 1'b0;
        wait_key(1'b0, 100, n, ok);
        wait_ok(ok, "op_key_fall");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        bit ok;
        int n;
        int highs;
        highs = 0;
        exp_q.push_back('{num: 4'd0, sym: 4'b0001});
        press(2'd2, 4'b1011);
        for (int i = 0; i < 60; i++) begin
            pressed = ((i / 5) % 2 == 0);
            @(negedge clk);
            if (key !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin errors++; $display("FAIL bounce_quiet: key high %0d cycles required 0", highs); end
        pressed = 1'b1;
        wait_key(1'b1, 300, n, ok);
        wait_ok(ok, "bounce_key_rise");
        checks++;
        if (n < DEBOUNCE_CYC + 1) begin
            errors++;
            $display("FAIL bounce_latency: %0d cycles required at least %0d", n, DEBOUNCE_CYC + 1);
        end
        repeat (20) @(negedge clk);
        pressed = 1'b0;
        wait_key(1'b0, 100, n, ok);
        wait_ok(ok, "bounce_key_fall");
        repeat (40) @(negedge clk);
    endtask

    task automatic test_multi();
        int highs;
        int changes;
        logic [3:0] last_row;
        highs   = 0;
        changes = 0;
        press(2'd1, 4'b1100);
        last_row = row;
        repeat (50) begin
            @(negedge clk);
            if (key !== 1'b0) highs++;
            if (row !== last_row) changes++;
            last_row = row;
        end
        pressed = 1'b0;
        checks += 2;
        if (highs != 0) begin errors++; $display("FAIL multi_reject: key high %0d cycles required 0", highs); end
        if (changes < 2) begin errors++; $display("FAIL multi_rotation: %0d row changes required at least 2", changes); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_second_key();
        bit ok;
        int n;
        int bad;
        exp_q.push_back('{num: 4'd5, sym: 4'b1111});
        press(2'd1, 4'b1101);
        wait_key(1'b1, 300, n, ok);
        wait_ok(ok, "second_key_rise");
        press_mask = 4'b1100;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (key !== 1'b1 || num !== 4'd5 || symbol !== 4'b1111) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL second_key_ignored: %0d bad cycles required 0", bad); end
        press_mask = 4'b1101;
        repeat (5) @(negedge clk);
        pressed = 1'b0;
        wait_key(1'b0, 100, n, ok);
        wait_ok(ok, "second_key_fall");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_release_bounce();
        bit ok;
        int n;
        int drop;
        exp_q.push_back('{num: 4'd3, sym: 4'b1111});
        press(2'd0, 4'b0111);
        wait_key(1'b1, 300, n, ok);
        wait_ok(ok, "relb_key_rise");
        repeat (10) @(negedge clk);
        drop = -1;
        for (int k = 0; k < 60; k++) begin
            if (key === 1'b0 && drop < 0) drop = k;
            pressed = (k >= 3 && k <= 5);
            @(negedge clk);
        end
        checks += 2;
        if (drop != DROP_BOUNCE) begin
            errors++;
            $display("FAIL release_bounce_time: key fell at %0d required %0d", drop, DROP_BOUNCE);
        end
        if (num !== 4'd3) begin errors++; $display("FAIL release_bounce_num: num=%0d required 3", num); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_midpress();
        bit ok;
        int n;
        exp_q.push_back('{num: 4'd7, sym: 4'b1111});
        press(2'd1, 4'b0111);
        wait_key(1'b1, 300, n, ok);
        wait_ok(ok, "rst_key_rise");
        repeat (40) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 4;
        if (key !== 1'b0) begin errors++; $display("FAIL midpress_key: key=%b required 0", key); end
        if (row !== 4'b1110) begin errors++; $display("FAIL midpress_row: row=%b required 1110", row); end
        if (num !== 4'd0) begin errors++; $display("FAIL midpress_num: num=%0d required 0", num); end
        if (symbol !== 4'b0000) begin errors++; $display("FAIL midpress_symbol: symbol=%b required 0000", symbol); end
        exp_q.push_back('{num: 4'd7, sym: 4'b1111});
        reset = 1'b1;
        wait_key(1'b1, 300, n, ok);
        wait_ok(ok, "rst_key_rerise");
        checks++;
        if (n < DEBOUNCE_CYC + 1) begin
            errors++;
            $display("FAIL midpress_redebounce: %0d cycles required at least %0d", n, DEBOUNCE_CYC + 1);
        end
        pressed = 1'b0;
        wait_key(1'b0, 100, n, ok);
        wait_ok(ok, "rst_key_fall");
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        pressed    = 1'b0;
        press_row  = 2'd0;
        press_mask = 4'b1111;
        test_reset();
        test_rotation();
        test_digit();
        test_operator();
        test_bounce();
        test_multi();
        test_second_key();
        test_release_bounce();
        test_reset_midpress();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d accepts outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each row is driven before advancing to the next row (minimum 4).
REQ-002 Parameter DEBOUNCE_CYC, default 200000: consecutive clk cycles a column pattern must stay stable to be accepted (minimum 2).
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 col  input  4  keypad column sense lines, active-low, externally pulled up, asynchronous.
REQ-006 row  output  4  keypad row drive lines, active-low, at most one bit low at any time.
REQ-007 num  output  4  digit value 0-9 of the accepted key; 4'b0000 for operator keys.
REQ-008 symbol  output  4  key class: 4'b1111 digit, 0001 +, 0010 -, 0011 and, 0100 =, 0101 cmp, 0110 or.
REQ-009 key  output  1  high while a debounced key is held; level, not pulse.

Function
REQ-010 col SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (cols_s).
REQ-011 Key code SHALL be {row_index[1:0], col_index[1:0]}; codes 0-9 map to digits 0-9; codes 10-15 map to +, -, and, =, cmp, or.
REQ-012 States SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SCAN: row rotates 1110->1101->1011->0111->1110, one step every SCAN_DIV cycles; cols_s != 4'b1111 in the last cycle of a row slot -> latch row index and cols_s, freeze row, go to DEBOUNCE.
REQ-014 DEBOUNCE: count cycles while cols_s equals the latched pattern; any mismatch -> back to SCAN and continue rotation from the next row; count reaching DEBOUNCE_CYC with exactly one bit low -> load num/symbol, assert key, go to PRESSED.
REQ-015 More than one column low in the latched pattern SHALL be rejected: key stays 0 and the FSM returns to SCAN after the debounce interval.
REQ-016 num and symbol SHALL update in the same cycle key rises and SHALL hold stable while key=1 and after key falls, until the next acceptance.
REQ-017 PRESSED: row stays frozen; cols_s == 4'b1111 -> go to RELEASE.
REQ-018 A second key pressed while in PRESSED SHALL be ignored; no output change.
REQ-019 Latency from a stable synchronized press in the frozen row to key=1 SHALL be exactly DEBOUNCE_CYC+1 cycles.

Reset
REQ-020 While reset=0 at a clk edge: state SCAN, row=4'b1110, num=4'b0000, symbol=4'b0000, key=0, all counters and the synchronizer cleared to idle (sync flops = 1).
REQ-021 Reset asserted mid-press SHALL drop key on the same edge; a still-held key SHALL be re-detected only through a full debounce.

Configuration
REQ-022 Macro KEYPAD_RELEASE_DEBOUNCE_EN defined: RELEASE requires cols_s == 4'b1111 for DEBOUNCE_CYC consecutive cycles before clearing key and returning to SCAN; any low column restarts the count and stays in RELEASE.
REQ-023 Macro undefined: RELEASE clears key on the next cycle and returns to SCAN with row=4'b1110.

Verification (SCAN_DIV=8, DEBOUNCE_CYC=16)
REQ-024 Press row 0 col 2 (code 2), hold 100 cycles -> key=1, num=2, symbol=1111; release -> key=0, num stays 2.
REQ-025 Press row 3 col 1 (code 13) -> key=1, symbol=0100, num=0000.
REQ-026 Press row 2 col 2 (code 10) bouncing every 5 cycles for 60 cycles, then stable -> single key assertion only after 16 stable cycles, symbol=0001.
REQ-027 Row 1 cols 0 and 1 low together for 50 cycles -> key never asserts, rotation resumes.
REQ-028 Hold code 7, assert reset for 1 cycle at cycle 40 of hold -> key=0, row=1110 next cycle; key reasserts, num=7, after re-debounce.
REQ-029 With KEYPAD_RELEASE_DEBOUNCE_EN, release with 3-cycle bounce -> key stays 1 until 16 clean high cycles; without the macro -> key drops 1 cycle after first release.
